// File: rtl/sync_d_ff_if.sv
// -----------------------------------------------------------------------------
// sync_d_ff_if
// Data/output bundle for the sync_d_ff register.
//
// Signals:
//   d   WIDTH  data input, sampled by the register on the rising clock edge
//   q1  WIDTH  stored value (true output)
//   q2  WIDTH  bitwise complement of the stored value
//
// Modports:
//   master  drives d, observes q1/q2 (the block feeding the register)
//   slave   receives d, drives q1/q2 (the register itself)
// -----------------------------------------------------------------------------
interface sync_d_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;

  modport master (
    output d,
    input  q1,
    input  q2
  );

  modport slave (
    input  d,
    output q1,
    output q2
  );
endinterface

// File: rtl/sync_d_ff.sv
// -----------------------------------------------------------------------------
// sync_d_ff
// Positive-edge D register with true and complement outputs.
//
// Parameters:
//   WIDTH        data width in bits (>= 1)
//   RESET_VALUE  value held in the register while rst is high
//
// Ports:
//   clk   in     rising-edge clock
//   rst   in     asynchronous, active-high reset
//   bus   slave  d in, q1 = stored value, q2 = ~stored value
//
// Both outputs come straight off the single state register, so q2 is the
// exact complement of q1 at every instant (reset included) and neither
// output has a combinational path from d.
// -----------------------------------------------------------------------------
module sync_d_ff #(
  parameter int                WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst,
  sync_d_ff_if.slave bus
);

  logic [WIDTH-1:0] state_r;

  // State register: reset overrides any coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RESET_VALUE;
    end else begin
      state_r <= bus.d;
    end
  end

  assign bus.q1 = state_r;
  assign bus.q2 = ~state_r;

endmodule

// File: tb/tb_sync_d_ff.sv
// -----------------------------------------------------------------------------
// tb_sync_d_ff
// Drives two register instances side by side from one clock and reset:
//   u_dut1  WIDTH=1, RESET_VALUE=0
//   u_dut8  WIDTH=8, RESET_VALUE=8'hA5
// Expected outputs are pushed into a queue when stimulus is applied and
// popped at each observation point.
// -----------------------------------------------------------------------------
module tb_sync_d_ff;

  localparam logic [7:0] RV8 = 8'hA5;

  typedef struct {
    logic [0:0] e1;
    logic [7:0] e8;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  sync_d_ff_if #(.WIDTH(1)) bus1 ();
  sync_d_ff_if #(.WIDTH(8)) bus8 ();

  sync_d_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  sync_d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic push(input logic [0:0] e1, input logic [7:0] e8);
    exp_t e;
    e.e1 = e1;
    e.e8 = e8;
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop one expectation and compare q1/q2 of both instances against it.
  task automatic pop_check(input string tag);
    exp_t       e;
    logic [0:0] n1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_empty: observed empty scoreboard expected entry", tag);
    end else begin
      e  = sb_q.pop_front();
      n1 = ~e.e1;
      check({tag, "_q1_w1"}, {7'd0, bus1.q1}, {7'd0, e.e1});
      check({tag, "_q2_w1"}, {7'd0, bus1.q2}, {7'd0, n1});
      check({tag, "_q1_w8"}, bus8.q1, e.e8);
      check({tag, "_q2_w8"}, bus8.q2, ~e.e8);
    end
  endtask

  initial begin
    logic       r;
    logic [0:0] d1;
    logic [7:0] d8;
    checks = 0;
    errors = 0;

    // Reset from time zero with D at a non-reset value.
    rst    = 1'b1;
    bus1.d = 1'b1;
    bus8.d = 8'hFF;
    wait_until(1);  push(1'b0, RV8);   pop_check("reset_async");
    wait_until(6);  push(1'b0, RV8);   pop_check("reset_holds_edge");

    // Release reset: no change until the next rising edge.
    wait_until(10); rst = 1'b0; bus1.d = 1'b1; bus8.d = 8'h3C;
    wait_until(12); push(1'b0, RV8);   pop_check("rst_fall_no_change");
    wait_until(16); push(1'b1, 8'h3C); pop_check("capture_1");

    // Load 0, and D changes between edges do not pass through.
    wait_until(20); bus1.d = 1'b0; bus8.d = 8'h00;
    wait_until(22); push(1'b1, 8'h3C); pop_check("no_transparency");
    wait_until(26); push(1'b0, 8'h00); pop_check("load_0");
    wait_until(30); bus1.d = 1'b1; bus8.d = 8'hFF;
    wait_until(32); push(1'b0, 8'h00); pop_check("hold_until_edge");
    wait_until(36); push(1'b1, 8'hFF); pop_check("load_1");

    // Async reset with clock low, then an edge with D=1 while held.
    wait_until(40); rst = 1'b1;
    wait_until(41); push(1'b0, RV8);   pop_check("async_reset_clk_low");
    wait_until(46); push(1'b0, RV8);   pop_check("reset_ignores_edge");

    // Capture, then async reset while clock is high.
    wait_until(50); rst = 1'b0; bus1.d = 1'b1; bus8.d = 8'h81;
    wait_until(56); push(1'b1, 8'h81); pop_check("capture_after_reset");
    wait_until(57); rst = 1'b1;
    wait_until(58); push(1'b0, RV8);   pop_check("async_reset_clk_high");

    // Reset rising together with a clock edge: reset wins.
    wait_until(60); rst = 1'b0; bus1.d = 1'b1; bus8.d = 8'h7E;
    wait_until(66); push(1'b1, 8'h7E); pop_check("capture_pre_race");
    wait_until(75); rst = 1'b1; bus1.d = 1'b1; bus8.d = 8'hC3;
    wait_until(76); push(1'b0, RV8);   pop_check("reset_wins_edge");
    wait_until(80); rst = 1'b0;

    // Random D/RST driven on falling edges, checked after each rising edge.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      r  = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      d1 = 1'($urandom_range(0, 1));
      d8 = 8'($urandom_range(0, 255));
      rst    = r;
      bus1.d = d1;
      bus8.d = d8;
      if (r) begin
        #1;
        push(1'b0, RV8);
        pop_check("rand_async_reset");
      end
      push(r ? 1'b0 : d1, r ? RV8 : d8);
      @(posedge clk);
      #1;
      pop_check("rand_edge");
    end

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
